// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
// Shares one level-sensitive latch (enable + data) among N_REQ requesters.
// A winner is chosen in IDLE, its data is presented on lat_d for a setup
// cycle, lat_en is opened for EN_CYCLES cycles, then closed for a hold cycle
// during which the winner receives a one-cycle gnt pulse.
// Optional build macro: LATCH_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin; timing is identical.
// All outputs are registered so lat_en is glitch-free and never moves in
// the same cycle as lat_d.
module latch_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       lat_d,
    output logic                lat_en,
    output logic                busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (EN_CYCLES > 0) ? $clog2(EN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        CLOSE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [IW-1:0]    winner_q, winner_d;
    logic [DW-1:0]    lat_d_q,  lat_d_d;
    logic             lat_en_q, lat_en_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic             busy_q,   busy_d;

`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [IW-1:0]    ptr_q,    ptr_d;
`endif

    // Arbitration result for the current req vector
    logic             found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    scan_idx;
    logic [31:0]      scan_base;

    // Search for the first set req bit starting at the scan base, wrapping
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
`ifdef LATCH_ARB_FIXED_PRIO_EN
        scan_base = '0;
`else
        scan_base = 32'(ptr_q);
`endif
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = IW'((scan_base + i) % N_REQ);
            if (!found && req[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Next-state logic and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        lat_d_d  = lat_d_q;
`ifndef LATCH_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        lat_en_d = 1'b0;
        gnt_d    = '0;
        busy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    winner_d = win_idx;
                    lat_d_d  = wdata[win_idx*DW +: DW];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = OPEN;
            end
            OPEN: begin
                if (cnt_q == CW'(EN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = CLOSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLOSE: begin
`ifndef LATCH_ARB_FIXED_PRIO_EN
                if (winner_q == IW'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = winner_q + 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered
        lat_en_d = (state_d == OPEN);
        busy_d   = (state_d != IDLE);
        if (state_d == CLOSE) begin
            gnt_d[winner_d] = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            winner_q <= '0;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign lat_d  = lat_d_q;
    assign lat_en = lat_en_q;
    assign busy   = busy_q;

endmodule
